// File: rtl/fb_rect_fill.sv
// fb_rect_fill: solid-colour rectangle writer for a row-major 3-bpp frame buffer.
// Optional clipping to the frame buffer bounds is enabled by defining FB_RECT_CLIP_EN.
`default_nettype none

module fb_rect_fill #(
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 120
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_x0_i,
    input  logic [7:0]  cmd_y0_i,
    input  logic [7:0]  cmd_w_i,
    input  logic [7:0]  cmd_h_i,
    input  logic [2:0]  cmd_color_i,
    output logic        fb_we_o,
    input  logic        fb_grant_i,
    output logic [15:0] fb_addr_o,
    output logic [2:0]  fb_data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_FILL   = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [15:0] ROW_STEP = 16'(FB_WIDTH);

    logic [1:0]  state_q, state_d;
    logic [7:0]  x0_q, x0_d;
    logic [7:0]  w_q, w_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [15:0] row_base_q, row_base_d;
    logic [15:0] addr_q, addr_d;
    logic [2:0]  color_q, color_d;
    logic        we_q, we_d;

    logic [7:0]  w_eff, h_eff;
    logic [15:0] row0_base;
    logic        accept, zero_area, last_col, last_row;

`ifdef FB_RECT_CLIP_EN
    localparam logic [8:0] W_LIM = 9'(FB_WIDTH);
    localparam logic [8:0] H_LIM = 9'(FB_HEIGHT);
    logic [8:0] w_room, h_room;

    // Room to the right/bottom edge; an origin outside the buffer leaves no room at all.
    always_comb begin
        w_room = '0;
        h_room = '0;
        if (({1'b0, cmd_x0_i} < W_LIM) && ({1'b0, cmd_y0_i} < H_LIM)) begin
            w_room = W_LIM - {1'b0, cmd_x0_i};
            h_room = H_LIM - {1'b0, cmd_y0_i};
        end
        w_eff = 8'(({1'b0, cmd_w_i} < w_room) ? {1'b0, cmd_w_i} : w_room);
        h_eff = 8'(({1'b0, cmd_h_i} < h_room) ? {1'b0, cmd_h_i} : h_room);
    end
`else
    always_comb begin
        w_eff = cmd_w_i;
        h_eff = cmd_h_i;
    end
`endif

    assign accept    = (state_q == S_IDLE) && cmd_valid_i;
    assign zero_area = (w_eff == 8'd0) || (h_eff == 8'd0);
    assign row0_base = {8'd0, cmd_y0_i} * ROW_STEP;
    assign last_col  = (col_q == w_q - 8'd1);
    assign last_row  = (row_q == h_q - 8'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = zero_area ? S_DONE : S_FILL;
            S_FILL:  if (fb_grant_i && last_col && last_row) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == S_IDLE) && rst_ni;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
    end

    // Write-side datapath: the address is carried forward by increments, never re-multiplied.
    always_comb begin
        x0_d       = x0_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        color_d    = color_q;
        we_d       = we_q;
        if (accept) begin
            x0_d       = cmd_x0_i;
            w_d        = w_eff;
            h_d        = h_eff;
            col_d      = 8'd0;
            row_d      = 8'd0;
            row_base_d = row0_base;
            addr_d     = row0_base + {8'd0, cmd_x0_i};
            color_d    = cmd_color_i;
            we_d       = !zero_area;
        end else if ((state_q == S_FILL) && fb_grant_i) begin
            if (last_col && last_row) begin
                we_d = 1'b0;
            end else if (last_col) begin
                col_d      = 8'd0;
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + ROW_STEP;
                addr_d     = row_base_q + ROW_STEP + {8'd0, x0_q};
            end else begin
                col_d  = col_q + 8'd1;
                addr_d = addr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            color_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            x0_q       <= x0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            color_q    <= color_d;
            we_q       <= we_d;
        end
    end

    assign fb_we_o   = we_q;
    assign fb_addr_o = addr_q;
    assign fb_data_o = color_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: directed self-checking bench for fb_rect_fill.
`default_nettype none

module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
    logic [2:0]  cmd_color = '0;
    logic        fb_we;
    logic        fb_grant = 1'b1;
    logic [15:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    fb_rect_fill #(.FB_WIDTH(160), .FB_HEIGHT(120)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_x0_i    (cmd_x0),
        .cmd_y0_i    (cmd_y0),
        .cmd_w_i     (cmd_w),
        .cmd_h_i     (cmd_h),
        .cmd_color_i (cmd_color),
        .fb_we_o     (fb_we),
        .fb_grant_i  (fb_grant),
        .fb_addr_o   (fb_addr),
        .fb_data_o   (fb_data),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x0, input logic [7:0] y0,
                        input logic [7:0] w, input logic [7:0] h, input logic [2:0] c);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_a [4];
        logic [15:0] first3 [3];
        int cnt, dones, seq_err;

        exp_a[0] = 16'd163; exp_a[1] = 16'd164; exp_a[2] = 16'd323; exp_a[3] = 16'd324;

        // Reset values
        #12;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_we",    32'(fb_we),     32'd0);
        chk("rst_addr",  32'(fb_addr),   32'd0);
        chk("rst_data",  32'(fb_data),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Basic rect, grant held high
        fb_grant = 1'b1;
        send(8'd3, 8'd1, 8'd2, 8'd2, 3'd5);
        for (int i = 0; i < 4; i++) begin
            chk("basic_we",   32'(fb_we),   32'd1);
            chk("basic_addr", 32'(fb_addr), 32'(exp_a[i]));
            chk("basic_data", 32'(fb_data), 32'd5);
            chk("basic_busy", 32'(busy),    32'd1);
            chk("basic_rdy",  32'(cmd_ready), 32'd0);
            step();
        end
        chk("basic_done",    32'(done),  32'd1);
        chk("basic_we_off",  32'(fb_we), 32'd0);
        step();
        chk("basic_done_off", 32'(done),      32'd0);
        chk("basic_ready",    32'(cmd_ready), 32'd1);

        // Grant stall on every second cycle
        send(8'd3, 8'd1, 8'd2, 8'd2, 3'd5);
        for (int i = 0; i < 4; i++) begin
            fb_grant = 1'b0;
            chk("stall_we_hold",   32'(fb_we),   32'd1);
            chk("stall_addr_hold", 32'(fb_addr), 32'(exp_a[i]));
            chk("stall_done_early", 32'(done),   32'd0);
            step();
            fb_grant = 1'b1;
            chk("stall_addr_grant", 32'(fb_addr), 32'(exp_a[i]));
            chk("stall_data",       32'(fb_data), 32'd5);
            step();
        end
        chk("stall_done", 32'(done),  32'd1);
        chk("stall_we",   32'(fb_we), 32'd0);
        step();
        chk("stall_ready", 32'(cmd_ready), 32'd1);

        // Zero area
        send(8'd10, 8'd10, 8'd0, 8'd7, 3'd2);
        chk("zero_done", 32'(done),  32'd1);
        chk("zero_we",   32'(fb_we), 32'd0);
        chk("zero_busy", 32'(busy),  32'd1);
        step();
        chk("zero_done_off", 32'(done),      32'd0);
        chk("zero_we_off",   32'(fb_we),     32'd0);
        chk("zero_ready",    32'(cmd_ready), 32'd1);

        // Bottom-right corner overflow
        send(8'd158, 8'd119, 8'd5, 8'd3, 3'd7);
        cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (fb_we) begin
                if (cnt < 3) first3[cnt] = fb_addr;
                cnt++;
            end
            step();
        end
        chk("edge_done", 32'(done), 32'd1);
        chk("edge_a0", 32'(first3[0]), 32'd19198);
        chk("edge_a1", 32'(first3[1]), 32'd19199);
`ifdef FB_RECT_CLIP_EN
        chk("edge_count", 32'(cnt), 32'd2);
`else
        chk("edge_a2",    32'(first3[2]), 32'd19200);
        chk("edge_count", 32'(cnt), 32'd15);
`endif
        step();

        // Full screen
        send(8'd0, 8'd0, 8'd160, 8'd120, 3'd3);
        cnt = 0; dones = 0; seq_err = 0;
        for (int i = 0; i < 19210; i++) begin
            if (fb_we) begin
                if (fb_addr != 16'(cnt)) seq_err++;
                cnt++;
            end
            if (done) dones++;
            step();
        end
        chk("full_count",   32'(cnt),     32'd19200);
        chk("full_seq_err", 32'(seq_err), 32'd0);
        chk("full_dones",   32'(dones),   32'd1);
        chk("full_ready",   32'(cmd_ready), 32'd1);

        // Reset during a 20x20 fill
        send(8'd2, 8'd3, 8'd20, 8'd20, 3'd6);
        for (int i = 0; i < 10; i++) begin
            chk("rf_addr", 32'(fb_addr), 32'd482 + 32'(i));
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("rf_we",    32'(fb_we),     32'd0);
        chk("rf_done",  32'(done),      32'd0);
        chk("rf_busy",  32'(busy),      32'd0);
        chk("rf_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("rf_done_hold", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rf_idle_busy", 32'(busy), 32'd0);
        send(8'd0, 8'd0, 8'd1, 8'd1, 3'd1);
        chk("one_we",   32'(fb_we),   32'd1);
        chk("one_addr", 32'(fb_addr), 32'd0);
        chk("one_data", 32'(fb_data), 32'd1);
        step();
        chk("one_done", 32'(done),  32'd1);
        chk("one_we_off", 32'(fb_we), 32'd0);
        step();
        chk("one_ready", 32'(cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
